// File: rtl/pdm_ser_fifo.sv
// pdm_ser_fifo: FIFO-buffered MSB-first PDM serializer on an open-drain pin.
// Optional macro PDM_SER_IDLE_TOGGLE_EN: toggle pattern on the pin during underrun.
module pdm_ser_fifo #(
    parameter int C_NR_OF_BITS = 32,
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_DIV_W      = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic                            flush_i,
    input  logic [C_DIV_W-1:0]              div_i,
    input  logic [C_NR_OF_BITS-1:0]         data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [$clog2(C_FIFO_DEPTH):0]   level_o,
    output logic                            done_o,
    output logic                            underrun_o,
    output logic                            pdm_clk_o,
    output logic                            pwm_audio_o,
    output logic                            pwm_audio_t,
    input  logic                            pwm_audio_i
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = $clog2(C_NR_OF_BITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_UNDER = 2'd2;

    logic [C_NR_OF_BITS-1:0] r_mem [C_FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;

    logic [1:0]              r_state;
    logic [C_NR_OF_BITS-1:0] r_shift;
    logic [CW-1:0]           r_bit_cnt;
    logic [C_DIV_W-1:0]      r_div_q;
    logic [C_DIV_W-1:0]      r_div_cnt;
    logic                    r_clk_int;
    logic                    r_done;
    logic                    r_under;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_div_wrap;
    logic w_bit_tick;
    logic w_last;
    logic w_start;
    logic w_reload;
    logic w_idle_level;
    logic w_unused;

    assign w_unused = pwm_audio_i;

    assign w_full  = (r_count == (AW+1)'(C_FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = valid_i && !w_full && !flush_i;

    // The shift happens on the edge where clk_int rises, so every
    // bit, including the first after a load, lasts 2*(div_q+1) cycles.
    assign w_div_wrap = (r_div_cnt == r_div_q);
    assign w_bit_tick = (r_state != S_IDLE) && w_div_wrap && !r_clk_int;
    assign w_last     = (r_bit_cnt == CW'(C_NR_OF_BITS - 1));

    assign w_start  = en_i && (r_state == S_IDLE) && !w_empty;
    assign w_reload = en_i && w_bit_tick && !w_empty &&
                      (((r_state == S_RUN) && w_last) || (r_state == S_UNDER));
    assign w_pop    = w_start || w_reload;

    // FIFO storage; entries need no reset since r_count gates reads
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // FIFO pointers and occupancy; flush wins over a same-cycle push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    // Bit divider, shift register and IDLE/RUN/UNDER sequencing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_q   <= '0;
            r_div_cnt <= '0;
            r_clk_int <= 1'b1;
            r_done    <= 1'b0;
            r_under   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_under <= 1'b0;
            if (!en_i) begin
                r_state   <= S_IDLE;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_div_cnt <= '0;
                r_clk_int <= 1'b1;
            end else begin
                if (r_state != S_IDLE) begin
                    if (w_div_wrap) begin
                        r_div_cnt <= '0;
                        r_clk_int <= !r_clk_int;
                    end else begin
                        r_div_cnt <= r_div_cnt + C_DIV_W'(1);
                    end
                end
                case (r_state)
                    S_IDLE: begin
                        if (!w_empty) begin
                            r_shift   <= r_mem[r_rd_ptr];
                            r_div_q   <= div_i;
                            r_bit_cnt <= '0;
                            r_div_cnt <= '0;
                            r_clk_int <= 1'b1;
                            r_state   <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_bit_tick) begin
                            if (w_last) begin
                                r_done    <= 1'b1;
                                r_bit_cnt <= '0;
                                if (!w_empty) begin
                                    r_shift <= r_mem[r_rd_ptr];
                                end else begin
                                    r_shift <= '0;
                                    r_under <= 1'b1;
                                    r_state <= S_UNDER;
                                end
                            end else begin
                                r_shift   <= {r_shift[C_NR_OF_BITS-2:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + CW'(1);
                            end
                        end
                    end
                    S_UNDER: begin
                        if (w_bit_tick && !w_empty) begin
                            r_shift   <= r_mem[r_rd_ptr];
                            r_bit_cnt <= '0;
                            r_state   <= S_RUN;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PDM_SER_IDLE_TOGGLE_EN
    logic r_idle_bit;

    // Zero-amplitude 1,0,1,0 pattern while starved, one value per bit period
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idle_bit <= 1'b0;
        end else if (!en_i) begin
            r_idle_bit <= 1'b0;
        end else if ((r_state == S_RUN) && w_bit_tick && w_last && w_empty) begin
            r_idle_bit <= 1'b1;
        end else if ((r_state == S_UNDER) && w_bit_tick) begin
            r_idle_bit <= !r_idle_bit;
        end
    end

    assign w_idle_level = r_idle_bit;
`else
    assign w_idle_level = 1'b0;
`endif

    assign ready_o    = !w_full;
    assign level_o    = r_count;
    assign done_o     = r_done;
    assign underrun_o = r_under;
    assign pdm_clk_o  = r_clk_int;
    assign pwm_audio_o = 1'b0;

    // Pin release level: data MSB in RUN, idle pattern in UNDER, low in IDLE
    always_comb begin
        pwm_audio_t = 1'b0;
        case (r_state)
            S_RUN:   pwm_audio_t = r_shift[C_NR_OF_BITS-1];
            S_UNDER: pwm_audio_t = w_idle_level;
            default: pwm_audio_t = 1'b0;
        endcase
    end

endmodule
